fht_but_sched: RTL

Sequencer that drives one pipelined FHT radix-2 butterfly (fht_but) through every stage of an N-point transform. It issues three read addresses per cycle to a ping-pong data memory and a twiddle ROM index. It then delays matching write-back addresses to the butterfly's outputs and sequences stages with pipeline drain. It sits between the top-level start/done control and the data RAM banks, the sin/cos ROM and the butterfly.

---
 rtl/fht_sched_pkg.sv | 16 +
 rtl/fht_sched_dly.sv | 34 +++
 rtl/fht_but_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fht_sched_pkg.sv
// Shared types and derived constants for the FHT butterfly scheduler.
package fht_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

    // Cycles from issue to write-back: one RAM read cycle plus the butterfly latency.
    function automatic int unsigned drain_cycles(input int unsigned but_lat);
        return 1 + but_lat;
    endfunction

endpackage

// File: rtl/fht_sched_dly.sv
// Valid-qualified shift register; carries issue-time addresses to later pipeline points.
module fht_sched_dly #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vin,
    input  logic [W-1:0] din,
    output logic         vout,
    output logic [W-1:0] dout
);

    logic [DEPTH-1:0] v_q;
    logic [W-1:0]     d_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
        end else begin
            v_q[0] <= vin;
            d_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i] <= v_q[i-1];
                d_q[i] <= d_q[i-1];
            end
        end
    end

    assign vout = v_q[DEPTH-1];
    assign dout = d_q[DEPTH-1];

endmodule

// File: rtl/fht_but_sched.sv
// Stage/op sequencer for a single pipelined radix-2 FHT butterfly over ping-pong RAM banks.
module fht_but_sched
    import fht_sched_pkg::*;
#(
    parameter int unsigned N       = 1024,
    parameter int unsigned LOG2N   = $clog2(N),
    parameter int unsigned BUT_LAT = 2
) (
    input  logic                       iCLK,
    input  logic                       iRESET,
    input  logic                       iSTART,
    output logic                       oBUSY,
    output logic                       oDONE,
    output logic [$clog2(LOG2N)-1:0]   oSTAGE,
    output logic                       oRD_BANK,
    output logic [LOG2N-1:0]           oRD_ADDR_0,
    output logic [LOG2N-1:0]           oRD_ADDR_1,
    output logic [LOG2N-1:0]           oRD_ADDR_2,
    output logic [LOG2N-2:0]           oROM_ADDR,
    output logic                       oWR_EN,
    output logic                       oWR_BANK,
    output logic [LOG2N-1:0]           oWR_ADDR_0,
    output logic [LOG2N-1:0]           oWR_ADDR_1
);

    localparam int unsigned SW = $clog2(LOG2N);
    localparam int unsigned JW = LOG2N - 1;
    localparam int unsigned D  = drain_cycles(BUT_LAT);
    localparam int unsigned CW = $clog2(D + 1);
    localparam int unsigned WW = 1 + 2 * LOG2N;

    localparam logic [JW-1:0] JLAST = JW'(N / 2 - 1);
    localparam logic [SW-1:0] SLAST = SW'(LOG2N - 1);
    localparam logic [CW-1:0] CLAST = CW'(D - 1);

    sched_state_t     state, state_nxt;
    logic [SW-1:0]    stage_nxt;
    logic [JW-1:0]    j, j_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             issue_nxt;

    logic [LOG2N-1:0] h, k, b;
    logic [LOG2N-1:0] x0_nxt, x1_nxt, x2_nxt;
    logic [JW-1:0]    rom_nxt;

    logic             iss_v;
    logic [LOG2N-1:0] iss_x0;
    logic             x0_v;
    logic [LOG2N-1:0] x0_a;
    logic [WW-1:0]    wr_d;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state plus the stage/op/drain counters; issue_nxt marks an op for the coming cycle.
    always_comb begin
        state_nxt = state;
        stage_nxt = oSTAGE;
        j_nxt     = j;
        cnt_nxt   = cnt;
        issue_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (iSTART) begin
                    state_nxt = RUN;
                    stage_nxt = '0;
                    j_nxt     = '0;
                    issue_nxt = 1'b1;
                end
            end
            RUN: begin
                if (j == JLAST) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    j_nxt     = j + JW'(1);
                    issue_nxt = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == CLAST) begin
                    if (oSTAGE == SLAST) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                        stage_nxt = oSTAGE + SW'(1);
                        j_nxt     = '0;
                        issue_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Butterfly operand addresses for the op about to be issued.
    always_comb begin
        h       = LOG2N'(1) << stage_nxt;
        k       = LOG2N'(j_nxt) & (h - LOG2N'(1));
        b       = ((LOG2N'(j_nxt) >> stage_nxt) << stage_nxt) << 1;
        x0_nxt  = b + k;
        x1_nxt  = b + h + k;
        x2_nxt  = b + h + ((h - k) & (h - LOG2N'(1)));
        rom_nxt = JW'(k << (SW'(LOG2N - 1) - stage_nxt));
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            oSTAGE     <= '0;
            j          <= '0;
            cnt        <= '0;
            oBUSY      <= 1'b0;
            oDONE      <= 1'b0;
            iss_v      <= 1'b0;
            iss_x0     <= '0;
            oRD_ADDR_1 <= '0;
            oRD_ADDR_2 <= '0;
            oROM_ADDR  <= '0;
        end else begin
            oSTAGE     <= stage_nxt;
            j          <= j_nxt;
            cnt        <= cnt_nxt;
            oBUSY      <= (state_nxt != IDLE);
            oDONE      <= (state_nxt == DONE);
            iss_v      <= issue_nxt;
            iss_x0     <= x0_nxt;
            oRD_ADDR_1 <= x1_nxt;
            oRD_ADDR_2 <= x2_nxt;
            oROM_ADDR  <= rom_nxt;
        end
    end

    assign oRD_BANK = oSTAGE[0];

    // x0 is consumed one cycle after x1/x2.
    fht_sched_dly #(.W(LOG2N), .DEPTH(1)) u_x0_dly (
        .clk   (iCLK),
        .rst_n (iRESET),
        .vin   (iss_v),
        .din   (iss_x0),
        .vout  (x0_v),
        .dout  (x0_a)
    );

    assign oRD_ADDR_0 = x0_v ? x0_a : '0;

    // Write-back destination and bank follow the op through the read + butterfly latency.
    fht_sched_dly #(.W(WW), .DEPTH(D)) u_wr_dly (
        .clk   (iCLK),
        .rst_n (iRESET),
        .vin   (iss_v),
        .din   ({~oSTAGE[0], iss_x0, oRD_ADDR_1}),
        .vout  (oWR_EN),
        .dout  (wr_d)
    );

    assign oWR_BANK   = wr_d[WW-1];
    assign oWR_ADDR_0 = wr_d[2*LOG2N-1:LOG2N];
    assign oWR_ADDR_1 = wr_d[LOG2N-1:0];

endmodule
